// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares one synchronous sprite ROM among N_REQ pixel-pipeline requesters.
// At most one ROM read is granted per cycle. The returned word is tagged back
// to the winner one cycle later with a one-hot rsp_valid. A requester that
// holds lock keeps the ROM for up to MAX_BURST consecutive grants. After that
// it must compete by round-robin again.
//
// Ports
//   vga_clk     in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   req         in   [N_REQ]          per-requester read request
//   lock        in   [N_REQ]          per-requester burst hold (with req)
//   addr        in   [N_REQ*ADDR_W]   request addresses, requester i at
//                                     [i*ADDR_W +: ADDR_W]
//   gnt         out  [N_REQ]          one-hot/zero grant, combinational
//   rom_address out  [ADDR_W]         address to the shared ROM
//   rom_q       in   [DATA_W]         ROM word, valid the cycle after address
//   rsp_valid   out  [N_REQ]          registered one-hot response tag
//   rsp_data    out  [DATA_W]         rom_q passthrough
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_BURST);
    localparam logic [OW-1:0] OWNER_RST = OW'(N_REQ - 1);

    logic [OW-1:0]     r_owner;
    logic [CW-1:0]     r_burst_cnt;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [ADDR_W-1:0] r_addr_hold;

    logic [ADDR_W-1:0] w_addr_arr [N_REQ];
    logic              w_found;
    logic [OW-1:0]     w_win;
    logic              w_lock_hold;
    logic [N_REQ-1:0]  w_gnt;
    logic [ADDR_W-1:0] w_rom_address;
    int                w_idx;

    // Unpack the flat address bus so the winner can be selected by index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
            assign w_addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // A nonzero burst count means the previous cycle granted the owner, so
    // the lock can only extend a streak that is already running and not yet
    // at its cap.
    assign w_lock_hold = req[r_owner] && lock[r_owner] &&
                         (r_burst_cnt != '0) && (r_burst_cnt < MAX_CNT);

    always_comb begin
        w_found = 1'b0;
        w_win   = r_owner;
        w_idx   = 0;
        if (w_lock_hold) begin
            w_found = 1'b1;
            w_win   = r_owner;
        end else begin
            // Scan owner+1 .. owner (inclusive) so the last winner ranks lowest.
            for (int k = 1; k <= N_REQ; k++) begin
                w_idx = int'(r_owner) + k;
                if (w_idx >= N_REQ) begin
                    w_idx = w_idx - N_REQ;
                end
                if (!w_found && req[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx[OW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_gnt         = '0;
        w_rom_address = '0;
        if (!reset) begin
            if (w_found) begin
                w_gnt[w_win]  = 1'b1;
                w_rom_address = w_addr_arr[w_win];
            end else begin
                // Idle: keep the ROM address stable so the ROM output does not churn.
                w_rom_address = r_addr_hold;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_owner     <= OWNER_RST;
            r_burst_cnt <= '0;
            r_rsp_valid <= '0;
            r_addr_hold <= '0;
        end else begin
            r_rsp_valid <= w_gnt;
            if (w_found) begin
                r_owner     <= w_win;
                r_addr_hold <= w_addr_arr[w_win];
                // Streak continues only for back-to-back grants to the same
                // owner. At the cap it restarts at 1 and never wraps to 0.
                if ((w_win == r_owner) && (r_burst_cnt != '0) &&
                    (r_burst_cnt < MAX_CNT)) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end else begin
                    r_burst_cnt <= CW'(1);
                end
            end else begin
                r_burst_cnt <= '0;
            end
        end
    end

    assign gnt         = w_gnt;
    assign rom_address = w_rom_address;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = rom_q;

endmodule
